// File: rtl/aes_sample_seq.sv
// AES stimulus/capture sequencer: LFSR-generated state/key words, programmable capture latency,
// valid/ready sample records. Optional MISR signature over captured outputs: define AES_SEQ_MISR_EN.
module aes_sample_seq #(
    parameter int          DATA_W      = 128,
    parameter int          PERIOD      = 32,
    parameter int          NUM_SAMPLES = 2000,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              fixed_key_mode,
    input  logic [DATA_W-1:0] fixed_key,
    output logic [DATA_W-1:0] key_o,
    output logic [DATA_W-1:0] state_o,
    input  logic [DATA_W-1:0] aes_out_i,
    output logic              busy,
    output logic              done,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic [CNT_W-1:0]  smp_idx,
    output logic [DATA_W-1:0] smp_key,
    output logic [DATA_W-1:0] smp_state,
    output logic [DATA_W-1:0] smp_out,
    output logic [DATA_W-1:0] sig
);
    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | 2*W cycles of LFSR words into state then key shadows
    // RUN   | PERIOD-cycle latency window before capture
    // WAIT  | record presented, waiting for smp_ready
    // DONE  | NUM_SAMPLES records delivered, outputs held
    localparam int W     = DATA_W / 32;
    localparam int TMAX  = (2 * W > PERIOD) ? 2 * W : PERIOD;
    localparam int TMR_W = $clog2(TMAX + 1);
    localparam logic [TMR_W-1:0] LD_LAST  = TMR_W'(2 * W - 1);
    localparam logic [TMR_W-1:0] LD_KEY   = TMR_W'(W - 1);
    localparam logic [TMR_W-1:0] RUN_LAST = TMR_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] NUM_LAST = CNT_W'(NUM_SAMPLES);
    localparam logic [31:0]      SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_WAIT, S_DONE} state_t;

    state_t            st;
    logic [31:0]       lfsr;
    logic [31:0]       lfsr_nx;
    logic [TMR_W-1:0]  tmr;
    logic [DATA_W-1:0] state_sh;
    logic [DATA_W-1:0] key_sh;
    logic [DATA_W-1:0] state_sh_nx;
    logic [DATA_W-1:0] key_sh_nx;
    logic              fk_mode_q;
    logic [DATA_W-1:0] fk_q;
    logic              go;
    logic              cap;

    assign lfsr_nx     = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'hA300_0000 : 32'h0);
    // First word shifted in ends at the MSB once W words have been loaded.
    assign state_sh_nx = DATA_W'({state_sh, lfsr_nx});
    assign key_sh_nx   = DATA_W'({key_sh, lfsr_nx});
    assign go          = ((st == S_IDLE) || (st == S_DONE)) && start;
    assign cap         = (st == S_RUN) && (tmr == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= S_IDLE;
            lfsr      <= SEED_EFF;
            tmr       <= '0;
            state_sh  <= '0;
            key_sh    <= '0;
            fk_mode_q <= 1'b0;
            fk_q      <= '0;
            key_o     <= '0;
            state_o   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            smp_valid <= 1'b0;
            smp_idx   <= '0;
            smp_key   <= '0;
            smp_state <= '0;
            smp_out   <= '0;
        end else if (abort) begin
            st        <= S_IDLE;
            tmr       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            smp_valid <= 1'b0;
            smp_idx   <= '0;
        end else begin
            case (st)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        st        <= S_LOAD;
                        tmr       <= LD_LAST;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fk_mode_q <= fixed_key_mode;
                        fk_q      <= fixed_key;
                        smp_idx   <= '0;
                    end
                end
                S_LOAD: begin
                    lfsr <= lfsr_nx;
                    if (tmr > LD_KEY) state_sh <= state_sh_nx;
                    else              key_sh   <= key_sh_nx;
                    if (tmr == '0) begin
                        state_o <= state_sh;
                        key_o   <= fk_mode_q ? fk_q : key_sh_nx;
                        tmr     <= RUN_LAST;
                        st      <= S_RUN;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_RUN: begin
                    if (tmr == '0) begin
                        smp_out   <= aes_out_i;
                        smp_key   <= key_o;
                        smp_state <= state_o;
                        smp_idx   <= smp_idx + CNT_W'(1);
                        smp_valid <= 1'b1;
                        st        <= S_WAIT;
                    end else begin
                        tmr <= tmr - TMR_W'(1);
                    end
                end
                S_WAIT: begin
                    if (smp_ready) begin
                        smp_valid <= 1'b0;
                        if (smp_idx == NUM_LAST) begin
                            st   <= S_DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            st  <= S_LOAD;
                            tmr <= LD_LAST;
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

`ifdef AES_SEQ_MISR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               sig <= '0;
        else if (abort || go)   sig <= '0;
        else if (cap)           sig <= {sig[DATA_W-2:0], sig[DATA_W-1]} ^ aes_out_i;
    end
`else
    assign sig = '0;
`endif

endmodule

// File: tb/tb_aes_sample_seq.sv
// Scoreboard bench for aes_sample_seq: an LFSR model queues expected records, a monitor checks handshakes.
module tb_aes_sample_seq;
    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic         fixed_key_mode;
    logic [127:0] fixed_key;
    logic [127:0] key_o;
    logic [127:0] state_o;
    logic [127:0] aes_out_i;
    logic         busy;
    logic         done;
    logic         smp_valid;
    logic         smp_ready;
    logic [15:0]  smp_idx;
    logic [127:0] smp_key;
    logic [127:0] smp_state;
    logic [127:0] smp_out;
    logic [127:0] sig;
    logic         use_const;

    typedef struct packed {
        logic [15:0]  idx;
        logic [127:0] key;
        logic [127:0] state;
        logic [127:0] out;
        logic [127:0] sig;
    } rec_t;

    rec_t         exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [31:0]  m_lfsr = 32'h1;
    logic [15:0]  m_idx;
    logic [127:0] m_sig;

    localparam logic [127:0] FK = 128'h00010203_04050607_08090A0B_0C0D0E0F;

    aes_sample_seq #(
        .DATA_W(128), .PERIOD(4), .NUM_SAMPLES(3), .CNT_W(16), .SEED(32'h1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .fixed_key_mode(fixed_key_mode), .fixed_key(fixed_key),
        .key_o(key_o), .state_o(state_o), .aes_out_i(aes_out_i),
        .busy(busy), .done(done), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_idx(smp_idx), .smp_key(smp_key), .smp_state(smp_state),
        .smp_out(smp_out), .sig(sig)
    );

    // Stand-in AES core: either a constant or a cheap function of the stimulus.
    assign aes_out_i = use_const ? 128'h1 : (key_o ^ state_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? 32'hA300_0000 : 32'h0);
    endfunction

    task automatic gen_exp(input bit fixed, output rec_t r);
        logic [127:0] st;
        logic [127:0] kw;
        st = '0;
        kw = '0;
        for (int i = 0; i < 4; i++) begin
            m_lfsr = lfsr_step(m_lfsr);
            st = {st[95:0], m_lfsr};
        end
        for (int i = 0; i < 4; i++) begin
            m_lfsr = lfsr_step(m_lfsr);
            kw = {kw[95:0], m_lfsr};
        end
        m_idx   = m_idx + 16'd1;
        r.idx   = m_idx;
        r.state = st;
        r.key   = fixed ? FK : kw;
        r.out   = use_const ? 128'h1 : (r.key ^ r.state);
`ifdef AES_SEQ_MISR_EN
        m_sig = {m_sig[126:0], m_sig[127]} ^ r.out;
        r.sig = m_sig;
`else
        r.sig = '0;
`endif
    endtask

    task automatic queue_run(input bit fixed, input int n);
        rec_t r;
        m_idx = '0;
        m_sig = '0;
        for (int i = 0; i < n; i++) begin
            gen_exp(fixed, r);
            exp_q.push_back(r);
        end
    endtask

    task automatic do_start(input bit fixed);
        fixed_key_mode = fixed;
        fixed_key      = FK;
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cnt);
        cnt = 0;
        while (done !== 1'b1 && cnt < max) begin
            tick();
            cnt++;
        end
        chk("done_reached", {127'b0, done}, 128'h1);
    endtask

    always @(negedge clk) begin
        if (rst && smp_valid && smp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_record: got idx %0d expected none", smp_idx);
            end else begin
                rec_t r;
                r = exp_q.pop_front();
                chk("rec_idx", {112'b0, smp_idx}, {112'b0, r.idx});
                chk("rec_state", smp_state, r.state);
                chk("rec_key", smp_key, r.key);
                chk("rec_out", smp_out, r.out);
                chk("rec_sig", sig, r.sig);
            end
        end
    end

    initial begin
        int   cnt;
        rec_t dummy;
        rst = 1'b0; start = 1'b0; abort = 1'b0; fixed_key_mode = 1'b0;
        fixed_key = '0; smp_ready = 1'b0; use_const = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_busy", {127'b0, busy}, 128'h0);
        chk("rst_done", {127'b0, done}, 128'h0);
        chk("rst_valid", {127'b0, smp_valid}, 128'h0);
        chk("rst_state_o", state_o, 128'h0);
        chk("rst_key_o", key_o, 128'h0);
        chk("rst_idx", {112'b0, smp_idx}, 128'h0);
        chk("rst_sig", sig, 128'h0);

        // Run A: random keys, ready held low for 10 cycles after the first record.
        queue_run(1'b0, 3);
        do_start(1'b0);
        chk("a_busy", {127'b0, busy}, 128'h1);
        repeat (7) tick();
        chk("a_state_pre", state_o, 128'h0);
        tick();
        chk("a_state_e8", state_o, 128'hA3000000_51800000_28C00000_14600000);
        chk("a_key_e8", key_o, exp_q[0].key);
        repeat (3) tick();
        chk("a_valid_e11", {127'b0, smp_valid}, 128'h0);
        tick();
        chk("a_valid_e12", {127'b0, smp_valid}, 128'h1);
        chk("a_idx_e12", {112'b0, smp_idx}, 128'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", {127'b0, smp_valid}, 128'h1);
            chk("bp_rec_state", smp_state, 128'hA3000000_51800000_28C00000_14600000);
            chk("bp_state_o", state_o, 128'hA3000000_51800000_28C00000_14600000);
            chk("bp_key_o", key_o, exp_q[0].key);
        end
        smp_ready = 1'b1;
        tick();
        chk("a_hs_valid", {127'b0, smp_valid}, 128'h0);
        chk("a_hs_busy", {127'b0, busy}, 128'h1);
        repeat (7) tick();
        chk("a_s2_pre", state_o, 128'hA3000000_51800000_28C00000_14600000);
        tick();
        chk("a_s2_state", state_o, exp_q[0].state);
        repeat (17) tick();
        chk("a_done_pre", {127'b0, done}, 128'h0);
        chk("a_idx3", {112'b0, smp_idx}, 128'h3);
        tick();
        chk("a_done", {127'b0, done}, 128'h1);
        chk("a_done_busy", {127'b0, busy}, 128'h0);

        // Run B: fixed key, restarted from DONE; LFSR continues.
        queue_run(1'b1, 3);
        do_start(1'b1);
        chk("b_idx_clr", {112'b0, smp_idx}, 128'h0);
        chk("b_done_clr", {127'b0, done}, 128'h0);
        repeat (12) tick();
        chk("b_idx1", {112'b0, smp_idx}, 128'h1);
        chk("b_key_fixed", key_o, FK);
        wait_done(60, cnt);
        chk("b_done_cycle", cnt, 128'd27);

        // Run C: abort during RUN of sample 2, then abort+start together.
        queue_run(1'b0, 1);
        gen_exp(1'b0, dummy);
        do_start(1'b0);
        repeat (23) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", {127'b0, busy}, 128'h0);
        chk("ab_valid", {127'b0, smp_valid}, 128'h0);
        chk("ab_idx", {112'b0, smp_idx}, 128'h0);
        chk("ab_done", {127'b0, done}, 128'h0);
        chk("ab_sig", sig, 128'h0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        tick();
        chk("abst_busy", {127'b0, busy}, 128'h0);

        // Run D: restart after abort, LFSR keeps its value.
        queue_run(1'b0, 3);
        do_start(1'b0);
        wait_done(60, cnt);
        chk("d_done_cycle", cnt, 128'd39);

        // Run E: constant core output exercises the signature.
        use_const = 1'b1;
        queue_run(1'b0, 3);
        do_start(1'b0);
        wait_done(60, cnt);
`ifdef AES_SEQ_MISR_EN
        chk("e_sig", sig, 128'h7);
`else
        chk("e_sig", sig, 128'h0);
`endif
        use_const = 1'b0;

        // Async reset mid-run.
        do_start(1'b0);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        chk("ar_busy", {127'b0, busy}, 128'h0);
        chk("ar_state_o", state_o, 128'h0);
        chk("ar_key_o", key_o, 128'h0);
        tick();
        rst = 1'b1;
        tick();

        chk("queue_empty", exp_q.size(), 128'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
